// File: rtl/led_bar_monitor.sv
// led_bar_monitor: watches the bouncing LED bar on each sample strobe and
// reports the lit group's position, width and direction of travel, counts
// direction reversals and latches a sticky error on illegal patterns.
// Optional feature macro: LED_BAR_MON_BOUNCE_CNT_EN builds the bounce counter;
// when undefined, bounce_cnt is tied to zero.
module led_bar_monitor #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned PW    = 4,
    parameter int unsigned CW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample,
    input  logic             clr,
    input  logic [WIDTH-1:0] bar,
    output logic             valid,
    output logic [PW-1:0]    pos,
    output logic [PW-1:0]    span,
    output logic             dir,
    output logic             moving,
    output logic [CW-1:0]    bounce_cnt,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, TRACK, ERR} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pos_d, span_d;
    logic            dir_d, moving_d, valid_d, err_d;
    logic [PW-1:0]   bar_lo, bar_hi, bar_n;
    logic            contig;

    // Decode lowest/highest lit LED and popcount of the current bar
    always_comb begin
        bar_lo = '0;
        bar_hi = '0;
        bar_n  = '0;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (bar[i-1]) bar_lo = PW'(i-1);
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bar[i]) begin
                bar_hi = PW'(i);
                bar_n  = bar_n + PW'(1);
            end
        end
    end

    assign contig = (bar_n == (bar_hi - bar_lo + PW'(1)));

    // Next-state and next-output logic; pos/span double as the previous
    // sample's lo/n, since they always hold exactly those values in TRACK.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos;
        span_d   = span;
        dir_d    = dir;
        moving_d = moving;
        valid_d  = valid;
        err_d    = err;
        if (clr) begin
            state_d  = IDLE;
            pos_d    = '0;
            span_d   = '0;
            dir_d    = 1'b0;
            moving_d = 1'b0;
            valid_d  = 1'b0;
            err_d    = 1'b0;
        end else if (sample) begin
            unique case (state_q)
                IDLE: begin
                    if (bar != '0) begin
                        if (!contig) begin
                            state_d  = ERR;
                            err_d    = 1'b1;
                            valid_d  = 1'b0;
                            moving_d = 1'b0;
                        end else begin
                            state_d  = TRACK;
                            pos_d    = bar_lo;
                            span_d   = bar_n;
                            valid_d  = 1'b1;
                            moving_d = 1'b0;
                            dir_d    = 1'b0;
                        end
                    end
                end
                TRACK: begin
                    if (bar == '0 || !contig || bar_n != span) begin
                        state_d  = ERR;
                        err_d    = 1'b1;
                        valid_d  = 1'b0;
                        moving_d = 1'b0;
                    end else if (bar_lo == pos) begin
                        moving_d = 1'b0;
                    end else if (bar_lo == pos + PW'(1)) begin
                        dir_d    = 1'b0;
                        moving_d = 1'b1;
                        pos_d    = bar_lo;
                    end else if (bar_lo == pos - PW'(1)) begin
                        dir_d    = 1'b1;
                        moving_d = 1'b1;
                        pos_d    = bar_lo;
                    end else begin
                        state_d  = ERR;
                        err_d    = 1'b1;
                        valid_d  = 1'b0;
                        moving_d = 1'b0;
                    end
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pos     <= '0;
            span    <= '0;
            dir     <= 1'b0;
            moving  <= 1'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            pos     <= pos_d;
            span    <= span_d;
            dir     <= dir_d;
            moving  <= moving_d;
            valid   <= valid_d;
            err     <= err_d;
        end
    end

`ifdef LED_BAR_MON_BOUNCE_CNT_EN
    logic [CW-1:0] cnt_q;
    logic          cnt_inc;

    // A reversal is a committed shift whose direction differs from the last one
    assign cnt_inc = sample && !clr && (state_q == TRACK) && moving_d && (dir_d != dir);

    // Saturating bounce counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (cnt_inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bounce_cnt = cnt_q;
`else
    assign bounce_cnt = '0;
`endif

endmodule

// File: tb/tb_led_bar_monitor.sv
// tb_led_bar_monitor: directed plus randomized stimulus for led_bar_monitor,
// checked against a behavioural model of the bar-tracking rules.
module tb_led_bar_monitor;

    logic        clk;
    logic        rst_n;
    logic        sample;
    logic        clr;
    logic [11:0] bar;
    logic        valid;
    logic [3:0]  pos;
    logic [3:0]  span;
    logic        dir;
    logic        moving;
    logic [15:0] bounce_cnt;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_track, m_err, m_valid, m_dir, m_mov;
    int m_pos, m_span, m_bnc;

    // Random bar generator state
    int gp, gw, gd;

    led_bar_monitor #(.WIDTH(12), .PW(4), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .sample(sample), .clr(clr), .bar(bar),
        .valid(valid), .pos(pos), .span(span), .dir(dir), .moving(moving),
        .bounce_cnt(bounce_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int exp_bnc;
`ifdef LED_BAR_MON_BOUNCE_CNT_EN
        exp_bnc = m_bnc;
`else
        exp_bnc = 0;
`endif
        check({tag, ".valid"},  32'(valid),      32'(m_valid));
        check({tag, ".pos"},    32'(pos),        32'(m_pos));
        check({tag, ".span"},   32'(span),       32'(m_span));
        check({tag, ".dir"},    32'(dir),        32'(m_dir));
        check({tag, ".moving"}, 32'(moving),     32'(m_mov));
        check({tag, ".bounce"}, 32'(bounce_cnt), 32'(exp_bnc));
        check({tag, ".err"},    32'(err),        32'(m_err));
    endtask

    task automatic model_reset();
        m_track = 0; m_err = 0; m_valid = 0; m_dir = 0; m_mov = 0;
        m_pos = 0; m_span = 0; m_bnc = 0;
    endtask

    task automatic model_go_err();
        m_err = 1; m_valid = 0; m_mov = 0; m_track = 0;
    endtask

    // Apply the tracking rules to one sampled bar
    task automatic model_step(input logic [11:0] b, input bit c);
        int lo, n;
        bit ok;
        logic [11:0] x;
        bit nd;
        if (c) begin
            model_reset();
            return;
        end
        if (m_err) return;
        lo = 0;
        for (int i = 11; i >= 0; i--) if (b[i]) lo = i;
        n  = $countones(b);
        x  = b >> lo;
        ok = (b != 0) && ((x & (x + 12'd1)) == 12'd0);
        if (!m_track) begin
            if (b == 0) return;
            if (!ok) begin
                model_go_err();
            end else begin
                m_track = 1; m_pos = lo; m_span = n; m_valid = 1; m_mov = 0; m_dir = 0;
            end
        end else begin
            if (!ok || n != m_span) begin
                model_go_err();
            end else if (lo == m_pos) begin
                m_mov = 0;
            end else if (lo == m_pos + 1 || lo == m_pos - 1) begin
                nd = (lo == m_pos - 1);
                if (nd != m_dir && m_bnc < 65535) m_bnc++;
                m_dir = nd; m_mov = 1; m_pos = lo;
            end else begin
                model_go_err();
            end
        end
    endtask

    // Drive one sample (optionally with clr) at a falling edge, check after the next
    task automatic step(input string tag, input logic [11:0] b, input bit c);
        sample = 1'b1;
        clr    = c;
        bar    = b;
        @(negedge clk);
        model_step(b, c);
        check_all(tag);
        sample = 1'b0;
        clr    = 1'b0;
    endtask

    // A cycle without sample must change nothing
    task automatic idle(input string tag);
        sample = 1'b0;
        clr    = 1'b0;
        bar    = 12'($urandom);
        @(negedge clk);
        check_all(tag);
    endtask

    function automatic logic [11:0] gen_bar();
        return 12'(((1 << gw) - 1) << gp);
    endfunction

    initial begin
        rst_n = 1'b0; sample = 1'b0; clr = 1'b0; bar = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all("reset");

        // Load and walk toward MSB
        step("load060", 12'h060, 0);
        step("walk0C0", 12'h0C0, 0);
        step("walk180", 12'h180, 0);
        step("walk300", 12'h300, 0);
        step("walk600", 12'h600, 0);
        step("walkC00", 12'hC00, 0);
        step("holdC00", 12'hC00, 0);
        step("back600", 12'h600, 0);
        // Down to the LSB end and back: second reversal
        for (int p = 8; p >= 0; p--) step("down", 12'(12'h003 << p), 0);
        step("hold003", 12'h003, 0);
        step("up006", 12'h006, 0);

        // Idle cycles freeze everything
        idle("idle1");
        idle("idle2");

        // Non-contiguous pattern, then frozen
        step("ncontig", 12'h0A0, 0);
        step("frozen1", 12'h00C, 0);
        step("frozen2", 12'h006, 0);

        // clr wins over a simultaneous sample
        step("clrerr", 12'h060, 1);
        step("reload", 12'h060, 0);

        // Jump by more than one LED
        step("jump180", 12'h180, 0);
        step("clr2", 12'h000, 1);

        // Width change and empty bar while tracking
        step("idlezero", 12'h000, 0);
        step("ld007", 12'h007, 0);
        step("width", 12'h00F, 0);
        step("clr3", 12'h000, 1);
        step("ld018", 12'h018, 0);
        step("empty", 12'h000, 0);
        step("clr4", 12'h000, 1);
        step("idlencon", 12'h801, 0);
        step("clr5", 12'h000, 1);

        // First move toward LSB right after load counts as a reversal
        step("ld300", 12'h300, 0);
        step("dn180", 12'h180, 0);

        // Randomized walks with holds, glitches, idles and clears
        gw = 2; gp = 7; gd = 1;
        for (int k = 0; k < 500; k++) begin
            int r;
            r = int'($urandom_range(0, 31));
            if (r == 0) begin
                step("rnd_any", 12'($urandom), 0);
            end else if (r == 1 || (m_err && r < 8)) begin
                gw = int'($urandom_range(1, 5));
                gp = int'($urandom_range(0, 12 - gw));
                step("rnd_clr", gen_bar(), 1);
            end else if (r == 2) begin
                idle("rnd_idle");
            end else begin
                if (r >= 6) begin
                    if (gd == 0) begin
                        if (gp + gw < 12) gp++; else gd = 1;
                    end else begin
                        if (gp > 0) gp--; else gd = 0;
                    end
                end
                step("rnd_walk", gen_bar(), 0);
            end
        end

        // Asynchronous reset mid-sweep, between clock edges
        step("pre_clr", 12'h000, 1);
        step("s_ld", 12'h030, 0);
        step("s_up", 12'h060, 0);
        sample = 1'b1; bar = 12'h0C0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sample = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        check_all("after_rst");
        step("post_ld", 12'h060, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
